led_pwm_dimmer: RTL

//   Downstream output stage for the 8-bit LED pattern bus: converts the pattern plus a global

---
 rtl/led_pwm_dimmer_if.sv | 14 +
 rtl/led_pwm_dimmer.sv | 95 +++++++++
 2 files changed

// File: rtl/led_pwm_dimmer_if.sv
// LED pattern bus into the PWM dimmer: requested pattern and brightness in, PWM drive and
// frame marker out. The pattern source uses the master modport, the dimmer the slave modport.
interface led_pwm_dimmer_if #(
    parameter int N_LED    = 8,
    parameter int PWM_BITS = 8
);
    logic [N_LED-1:0]    led_in;
    logic [PWM_BITS-1:0] bright;
    logic [N_LED-1:0]    led_out;
    logic                frame_start;

    modport master (output led_in, output bright, input led_out, input frame_start);
    modport slave  (input led_in, input bright, output led_out, output frame_start);
endinterface

// File: rtl/led_pwm_dimmer.sv
// Per-LED PWM output stage; duty values latch only at frame boundaries so pins never glitch.
// Define LED_PWM_FADE_EN to step each duty by one per frame toward its target instead of jumping.
module led_pwm_lane #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wrap_i,
    input  logic                lit_i,
    input  logic [PWM_BITS-1:0] bright_i,
    input  logic [PWM_BITS-1:0] cnt_i,
    output logic                led_o
);
    logic [PWM_BITS-1:0] duty_q, duty_d, target;
    logic                led_q;

    always_comb begin
        target = lit_i ? bright_i : '0;
        duty_d = duty_q;
        if (wrap_i) begin
`ifdef LED_PWM_FADE_EN
            if (duty_q < target)      duty_d = duty_q + 1'b1;
            else if (duty_q > target) duty_d = duty_q - 1'b1;
`else
            duty_d = target;
`endif
        end
    end

    // Compare uses the pre-edge duty, so a new duty shows at the pin one cycle after the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_q <= '0;
            led_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            led_q  <= (cnt_i < duty_q);
        end
    end

    assign led_o = led_q;
endmodule

module led_pwm_dimmer #(
    parameter int N_LED    = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 390
) (
    input  logic            clk,
    input  logic            rst,
    led_pwm_dimmer_if.slave bus
);
    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                fs_q;
    logic                step, wrap;
    logic [N_LED-1:0]    led_w;

    always_comb begin
        step  = (pre_q == PRE_LAST);
        wrap  = step && (&cnt_q);
        pre_d = step ? '0 : pre_q + 1'b1;
        cnt_d = step ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
            cnt_q <= '0;
            fs_q  <= 1'b0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            fs_q  <= wrap;
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_lane
        led_pwm_lane #(.PWM_BITS(PWM_BITS)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .wrap_i   (wrap),
            .lit_i    (bus.led_in[i]),
            .bright_i (bus.bright),
            .cnt_i    (cnt_q),
            .led_o    (led_w[i])
        );
    end

    assign bus.led_out     = led_w;
    assign bus.frame_start = fs_q;
endmodule
